// File: rtl/seq_pkg.sv
// Shared definitions for the word-to-serial scan controller and its sequence detector.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } scan_state_e;

   // Pattern set recognised by the detector; each pattern owns one bit of the match vector.
   localparam int NUM_PATTERNS = 2;
   localparam int PAT_ID_101   = 0;
   localparam int PAT_ID_0010  = 1;

   localparam logic [2:0] PAT_101  = 3'b101;
   localparam logic [3:0] PAT_0010 = 4'b0010;

endpackage

// File: rtl/seq_detector.sv
// Mealy detector for the "101" and "0010" serial patterns (overlapping matches allowed).
module seq_detector
   import seq_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic hit
);

   logic [2:0]              hist;
   logic [1:0]              depth;
   logic [NUM_PATTERNS-1:0] match;

   // depth guards against matching on history bits that were never streamed after a clear
   always_comb begin
      match              = '0;
      match[PAT_ID_101]  = (depth >= 2'd2) && ({hist[1:0], din} == PAT_101);
      match[PAT_ID_0010] = (depth == 2'd3) && ({hist, din} == PAT_0010);
   end

   assign hit = |match;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist  <= '0;
         depth <= '0;
      end else begin
         hist <= {hist[1:0], din};
         if (depth != 2'd3) begin
            depth <= depth + 2'd1;
         end
      end
   end

endmodule

// File: rtl/seq_scan_top.sv
// Scan controller paired with its serial sequence detector.
module seq_scan_top #(
   parameter int W  = 8,
   parameter int CW = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [W-1:0]  in_data,
   output logic          in_ready,
   input  logic          abort,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] hit_cnt,
   output logic [W-1:0]  hit_map
);

   logic det_din;
   logic det_rst_n;
   logic det_hit;

   seq_scan_ctrl #(.W(W), .CW(CW)) u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .hit_cnt   (hit_cnt),
      .hit_map   (hit_map),
      .det_din   (det_din),
      .det_rst_n (det_rst_n),
      .det_hit   (det_hit)
   );

   seq_detector u_det (
      .clk   (clk),
      .rst_n (det_rst_n),
      .din   (det_din),
      .hit   (det_hit)
   );

endmodule

// File: rtl/seq_scan_ctrl.sv
// Streams one W-bit word MSB-first into a serial detector and returns hit count and hit map.
// Handshakes: a transfer occurs on a rising edge where valid and ready are both high.
module seq_scan_ctrl
   import seq_pkg::*;
#(
   parameter int W  = 8,
   parameter int CW = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [W-1:0]  in_data,
   output logic          in_ready,
   input  logic          abort,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] hit_cnt,
   output logic [W-1:0]  hit_map,
   output logic          det_din,
   output logic          det_rst_n,
   input  logic          det_hit
);

   localparam int IW = $clog2(W);

   scan_state_e   state;
   scan_state_e   state_nxt;
   logic [W-1:0]  sreg;
   logic [IW-1:0] idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = SHIFT;
         SHIFT: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (idx == '0) begin
               state_nxt = DONE;
            end
         end
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Detector clear is registered so it releases exactly when the first bit appears on det_din.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg      <= '0;
         idx       <= '0;
         hit_cnt   <= '0;
         hit_map   <= '0;
         det_rst_n <= 1'b0;
      end else begin
         det_rst_n <= (state_nxt == SHIFT);
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sreg    <= in_data;
                  idx     <= IW'(W - 1);
                  hit_cnt <= '0;
                  hit_map <= '0;
               end
            end
            SHIFT: begin
               if (abort) begin
                  sreg    <= '0;
                  idx     <= '0;
                  hit_cnt <= '0;
                  hit_map <= '0;
               end else begin
                  if (det_hit) begin
                     hit_cnt      <= hit_cnt + CW'(1);
                     hit_map[idx] <= 1'b1;
                  end
                  sreg <= {sreg[W-2:0], 1'b0};
                  idx  <= idx - IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Zeros are shifted in, so the MSB is already 0 once a word is fully streamed or aborted.
   assign det_din   = sreg[W-1];
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: vector table for results plus hand-written corner sequences.
module tb_seq_scan_ctrl;

   localparam int W  = 8;
   localparam int CW = 4;

   typedef struct {
      logic [W-1:0]  data;
      logic [CW-1:0] cnt;
      logic [W-1:0]  map;
   } vec_t;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          in_ready;
   logic          abort;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] hit_cnt;
   logic [W-1:0]  hit_map;
   logic          det_din;
   logic          det_rst_n;
   logic          det_hit;

   logic          t_in_ready;
   logic          t_out_valid;
   logic [CW-1:0] t_hit_cnt;
   logic [W-1:0]  t_hit_map;

   int n_checks = 0;
   int n_errors = 0;

   vec_t vecs[7];
   logic [CW+W-1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   seq_scan_ctrl #(.W(W), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .hit_cnt   (hit_cnt),
      .hit_map   (hit_map),
      .det_din   (det_din),
      .det_rst_n (det_rst_n),
      .det_hit   (det_hit)
   );

   seq_detector u_det (
      .clk   (clk),
      .rst_n (det_rst_n),
      .din   (det_din),
      .hit   (det_hit)
   );

   seq_scan_top #(.W(W), .CW(CW)) u_top (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (t_in_ready),
      .abort     (abort),
      .out_valid (t_out_valid),
      .out_ready (out_ready),
      .hit_cnt   (t_hit_cnt),
      .hit_map   (t_hit_map)
   );

   // ---------------- scoreboard helper ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at a falling edge with the controller idle; returns at the falling edge where
   // out_valid is seen. lat counts rising edges from the accept edge inclusive.
   task automatic scan_word(input logic [W-1:0] d, output int lat, output int ir_bad);
      lat      = 0;
      ir_bad   = 0;
      in_data  = d;
      in_valid = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && lat < 40) begin
         if (in_ready) ir_bad++;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (in_ready) ir_bad++;
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, out_valid, 1'b0);
      check({tag, "_ready_back"}, in_ready, 1'b1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int lat;
      int ir_bad;
      int unstable;
      int seen;
      int n_acc;
      int first_acc;
      int second_acc;
      int low_cycles;
      int extra;
      logic [CW+W-1:0] e;

      vecs[0] = '{8'hA5, 4'd3, 8'h23};
      vecs[1] = '{8'h55, 4'd3, 8'h15};
      vecs[2] = '{8'h00, 4'd0, 8'h00};
      vecs[3] = '{8'hFF, 4'd0, 8'h00};
      vecs[4] = '{8'h92, 4'd2, 8'h09};
      vecs[5] = '{8'h2D, 4'd3, 8'h19};
      vecs[6] = '{8'h40, 4'd0, 8'h00};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      abort     = 1'b0;
      out_ready = 1'b0;

      #2;
      check("rst_in_ready",  in_ready,    1'b1);
      check("rst_out_valid", out_valid,   1'b0);
      check("rst_det_din",   det_din,     1'b0);
      check("rst_det_rst_n", det_rst_n,   1'b0);
      check("rst_hit_cnt",   hit_cnt,     4'd0);
      check("rst_hit_map",   hit_map,     8'h00);
      check("rst_top_valid", t_out_valid, 1'b0);

      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Table-driven single words
      for (int i = 0; i < 7; i++) begin
         scan_word(vecs[i].data, lat, ir_bad);
         check($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
         check($sformatf("vec%0d_latency", i), lat, W + 1);
         check($sformatf("vec%0d_hit_cnt", i), hit_cnt, vecs[i].cnt);
         check($sformatf("vec%0d_hit_map", i), hit_map, vecs[i].map);
         check($sformatf("vec%0d_in_ready_busy", i), ir_bad, 0);
         check($sformatf("vec%0d_top_valid", i), t_out_valid, 1'b1);
         check($sformatf("vec%0d_top_cnt", i), t_hit_cnt, vecs[i].cnt);
         check($sformatf("vec%0d_top_map", i), t_hit_map, vecs[i].map);
         release_result($sformatf("vec%0d", i));
      end

      // Result held while the consumer stalls; abort in DONE must be ignored
      scan_word(8'hA5, lat, ir_bad);
      unstable = 0;
      abort    = 1'b1;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         if (!out_valid || hit_cnt !== 4'd3 || hit_map !== 8'h23) unstable++;
      end
      abort = 1'b0;
      check("hold_stable", unstable, 0);
      #1 rst = 1'b1;
      #1;
      check("rst_done_valid", out_valid, 1'b0);
      check("rst_done_map",   hit_map,   8'h00);
      check("rst_done_ready", in_ready,  1'b1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Abort on the 4th SHIFT cycle of 8'hA5
      in_data  = 8'hA5;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("abort_pre_det_rst_n", det_rst_n, 1'b1);
      check("abort_pre_hit_cnt",   hit_cnt,   4'd1);
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_in_ready",  in_ready,  1'b1);
      check("abort_det_rst_n", det_rst_n, 1'b0);
      check("abort_det_din",   det_din,   1'b0);
      check("abort_hit_cnt",   hit_cnt,   4'd0);
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) seen++;
      end
      abort = 1'b0;
      check("abort_no_valid", seen, 0);
      scan_word(8'h55, lat, ir_bad);
      check("post_abort_cnt", hit_cnt, 4'd3);
      check("post_abort_map", hit_map, 8'h15);
      release_result("post_abort");

      // Back-to-back words with in_valid held high and a ready consumer
      exp_q.push_back({4'd3, 8'h23});
      exp_q.push_back({4'd3, 8'h15});
      in_data    = 8'hA5;
      in_valid   = 1'b1;
      out_ready  = 1'b1;
      n_acc      = 0;
      first_acc  = -1;
      second_acc = -1;
      low_cycles = 0;
      extra      = 0;
      for (int c = 0; c < 30; c++) begin
         if (!in_ready) low_cycles++;
         if (in_valid && in_ready) begin
            n_acc++;
            if (n_acc == 1) first_acc = c;
            else second_acc = c;
         end
         if (out_valid) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("b2b_result", {hit_cnt, hit_map}, e);
            end else begin
               extra++;
            end
         end
         @(posedge clk);
         @(negedge clk);
         if (n_acc == 1) in_data = 8'h55;
         if (n_acc == 2) in_valid = 1'b0;
      end
      out_ready = 1'b0;
      check("b2b_period",       second_acc - first_acc, W + 2);
      check("b2b_in_ready_low", low_cycles, 2 * (W + 1));
      check("b2b_pending",      exp_q.size(), 0);
      check("b2b_extra",        extra, 0);

      // Asynchronous reset in the middle of a scan
      in_data  = 8'hA5;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("mid_pre_det_din",   det_din,   1'b1);
      check("mid_pre_det_rst_n", det_rst_n, 1'b1);
      check("mid_pre_hit_cnt",   hit_cnt,   4'd1);
      check("mid_pre_hit_map",   hit_map,   8'h20);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_det_din",   det_din,   1'b0);
      check("mid_rst_det_rst_n", det_rst_n, 1'b0);
      check("mid_rst_hit_cnt",   hit_cnt,   4'd0);
      check("mid_rst_hit_map",   hit_map,   8'h00);
      check("mid_rst_in_ready",  in_ready,  1'b1);
      check("mid_rst_out_valid", out_valid, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      scan_word(8'h2D, lat, ir_bad);
      check("post_rst_cnt", hit_cnt, 4'd3);
      check("post_rst_map", hit_map, 8'h19);
      release_result("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Scan controller that feeds parallel words, one bit per clock, into an external serial sequence detector and reports the result. The detector flags "101" and "0010" patterns. For each accepted W-bit word the controller:
- resets the detector,
- streams the word MSB-first,
- samples the detector's same-cycle hit flag,
- returns a hit count and a per-bit hit map over a valid/ready handshake.

It sits between a word-oriented producer/consumer and the bit-serial detector datapath.

## Interface
- W, 8, word width in bits (W ≥ 2)
- CW, $clog2(W+1), hit-count width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  word offered
- in_data  in  W  word to scan; bit W-1 is streamed first
- in_ready  out  1  controller can accept a word
- abort  in  1  cancel the scan in progress
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- hit_cnt  out  CW  number of detector hits in the word
- hit_map  out  W  bit k set ⇒ hit reported while in_data[k] was on det_din
- det_din  out  1  serial bit to detector
- det_rst_n  out  1  detector synchronous active-low clear
- det_hit  in  1  detector hit flag (combinational in det_din and detector state)

## Operation
- Reset is asynchronous and active-high:
  - state = IDLE; shift register, counters, hit_cnt and hit_map = 0.
  - out_valid = 0, in_ready = 1, det_din = 0, det_rst_n = 0.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - Outputs: in_ready = 1, det_rst_n = 0 (detector held cleared), det_din = 0.
  - On in_valid & in_ready: load shift register ← in_data, bit index ← W-1, clear hit_cnt and hit_map, go to SHIFT.
- SHIFT:
  - Outputs: in_ready = 0, det_rst_n = 1, det_din = shift register MSB.
  - Each cycle, if det_hit = 1: hit_cnt += 1 and hit_map[index] ← 1.
  - Then shift left by one and decrement the index.
  - After the cycle with index 0, go to DONE.
- DONE:
  - Outputs: out_valid = 1, det_rst_n = 0, hit_cnt and hit_map stable.
  - On out_ready, go to IDLE.
  - in_ready stays 0 (no overlap between words).
- abort:
  - Sampled only in SHIFT; takes priority over the hit update.
  - Goes to IDLE and discards the partial result; out_valid never asserts for that word.
  - abort is ignored in IDLE and DONE.
- Every word is scanned from detector state s0; patterns never span words.
- hit_cnt cannot overflow, because CW covers 0..W.
- det_hit is ignored outside SHIFT.

## Timing
- Word accepted at edge T: SHIFT occupies cycles T..T+W-1, and out_valid rises after edge T+W.
  - Accept-to-result latency is W+1 cycles.
  - Minimum word period is W+2 cycles (includes one DONE cycle and one IDLE cycle).
- det_din changes only on clock edges. det_hit is sampled at the same edge that advances the detector with that bit.
- det_rst_n is registered and rises the cycle the first bit is presented. This gives one full reset-held cycle before every scan.
- out_valid & out_ready at edge E: out_valid = 0 and in_ready = 1 from E.
- Asynchronous rst mid-scan drops out_valid and det_rst_n immediately.

## Structure
- Shared package (seq_pkg):
  - state encoding localparams: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2, default → IDLE;
  - the pattern-set identifier constants.
- One state register plus one next-state always block.
- Datapath registers: shift register, index counter, hit_cnt, hit_map.
- Natural sub-module: seq_scan_top, which instantiates seq_scan_ctrl and the serial detector.
  - Wires det_din/det_hit across.
  - Maps det_rst_n to the detector's active-low reset.
  - The bench targets seq_scan_top.

## Test plan
- W=8, in_data=8'hA5 (stream 1,0,1,0,0,1,0,1) → hit_cnt=3, hit_map=8'b0010_0011, out_valid exactly 9 cycles after accept.
- in_data=8'h55 → hit_cnt=3, hit_map=8'b0001_0101.
- in_data=8'h00 and then 8'hFF → hit_cnt=0, hit_map=0 for both.
- Back-to-back words 8'hA5 then 8'h55 with in_valid held high → second result independent of first (3 / 8'b0001_0101); in_ready low from accept through DONE.
- abort asserted on the 4th SHIFT cycle of 8'hA5 → return to IDLE, no out_valid; next word 8'h55 gives the correct result.
- out_ready held low for 5 cycles in DONE → out_valid, hit_cnt and hit_map stable; rst pulsed mid-SHIFT → all outputs at reset values before the next clock edge.
